// File: rtl/data_mem_pkg.sv
// Shared encodings for the sized data memory: access sizes, fault codes, FSM states.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_SIZE  = 2'b01;
  localparam logic [1:0] FC_RANGE = 2'b10;
  localparam logic [1:0] FC_ALIGN = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Bytes touched by an access; the illegal encoding is treated as a word for the range math
  // but is rejected before range is considered.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word out of a big-endian array word and extends it to 32 bits.
// Lane 0 is the most significant byte of the array word.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and extension; halfword lanes are already known aligned when the result is used.
  always_comb begin
    byte_sel = word[31:24];
    half_sel = word[31:16];
    data     = word;
    case (lane)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: data = zero_ext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = zero_ext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Big-endian byte-addressed data memory behind the MEM stage. Stored as 32-bit words with
// byte enables; all legal accesses are aligned so each touches exactly one array word.
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int          MEM_DEPTH      = 1048576,
  parameter logic [31:0] BASE_ADDR      = 32'h80020000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_write_op,
  input  logic [1:0]  w_size,
  input  logic        w_unsigned,
  input  logic [31:0] w_addr_32,
  input  logic [31:0] w_data_in_32,
  output logic        w_rsp_valid,
  output logic [31:0] w_data_out_32,
  output logic        w_fault,
  output logic [1:0]  w_fault_code
);

  localparam int WORDS = MEM_DEPTH / 4;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  logic [31:0] mem [WORDS];

  state_t        state_q, state_d;
  logic [CW-1:0] clr_cnt;
  logic          ready_q;

  logic [31:0]   off;
  logic [32:0]   end_off;
  logic [1:0]    fault_code_c;
  logic          fault_c;
  logic          accept;
  logic [CW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;

  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_fault_q;
  logic [1:0]    rsp_code_q;

  assign w_req_ready   = ready_q;
  assign w_rsp_valid   = rsp_valid_q;
  assign w_data_out_32 = rsp_data_q;
  assign w_fault       = rsp_fault_q;
  assign w_fault_code  = rsp_code_q;

  assign accept  = w_req_valid && ready_q && !reset;
  assign off     = w_addr_32 - BASE_ADDR;
  assign end_off = {1'b0, off} + {30'b0, size_bytes(w_size)};
  assign lane    = off[1:0];
  assign widx    = off[CW+1:2];
  assign rd_word = mem[widx];

  // Next-state: CLEAR walks every word once, then IDLE forever until the next reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt == LAST_WORD) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fault classification in priority order; the 33-bit end offset lets addresses below BASE wrap high.
  always_comb begin
    fault_code_c = FC_NONE;
    if (w_size == SZ_ILLEGAL)
      fault_code_c = FC_SIZE;
    else if (end_off > 33'(MEM_DEPTH))
      fault_code_c = FC_RANGE;
    else if ((w_size == SZ_HALF && off[0]) || (w_size == SZ_WORD && off[1:0] != 2'b00))
      fault_code_c = FC_ALIGN;
  end

  assign fault_c = (fault_code_c != FC_NONE);

  // Store placement: replicate the source bytes across lanes and let the enables pick the target.
  always_comb begin
    wr_data = w_data_in_32;
    wr_be   = 4'b1111;
    case (w_size)
      SZ_BYTE: begin
        wr_data = {4{w_data_in_32[7:0]}};
        wr_be   = 4'b1000 >> lane;
      end
      SZ_HALF: begin
        wr_data = {2{w_data_in_32[15:0]}};
        wr_be   = lane[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        wr_data = w_data_in_32;
        wr_be   = 4'b1111;
      end
    endcase
  end

  load_extend u_load_extend (
    .word     (rd_word),
    .lane     (lane),
    .size     (w_size),
    .zero_ext (w_unsigned),
    .data     (ext_data)
  );

  // Array writes: zero-fill during CLEAR, otherwise non-faulting stores. Contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_cnt] <= 32'h0;
      end else if (accept && w_write_op && !fault_c) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[k]) mem[widx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Control state, clear counter and the registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_fault_q <= 1'b0;
      rsp_code_q  <= FC_NONE;
    end else begin
      state_q     <= state_d;
      clr_cnt     <= (state_q == ST_CLEAR) ? clr_cnt + CW'(1) : '0;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= accept;
      rsp_data_q  <= (accept && !w_write_op && !fault_c) ? ext_data : 32'h0;
      rsp_fault_q <= accept && fault_c;
      rsp_code_q  <= accept ? fault_code_c : FC_NONE;
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
module tb_data_mem_sized;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_req_valid = 1'b0;
  logic        w_req_ready;
  logic        w_write_op = 1'b0;
  logic [1:0]  w_size = 2'b00;
  logic        w_unsigned = 1'b0;
  logic [31:0] w_addr_32 = 32'h0;
  logic [31:0] w_data_in_32 = 32'h0;
  logic        w_rsp_valid;
  logic [31:0] w_data_out_32;
  logic        w_fault;
  logic [1:0]  w_fault_code;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [DEPTH];

  always #5 clock = ~clock;

  data_mem_sized #(
    .MEM_DEPTH      (DEPTH),
    .BASE_ADDR      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .w_req_valid   (w_req_valid),
    .w_req_ready   (w_req_ready),
    .w_write_op    (w_write_op),
    .w_size        (w_size),
    .w_unsigned    (w_unsigned),
    .w_addr_32     (w_addr_32),
    .w_data_in_32  (w_data_in_32),
    .w_rsp_valid   (w_rsp_valid),
    .w_data_out_32 (w_data_out_32),
    .w_fault       (w_fault),
    .w_fault_code  (w_fault_code)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic [1:0]  exp_c;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic [31:0] exp_d, input logic [1:0] exp_c);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.din = din;
    v.exp_d = exp_d; v.exp_c = exp_c;
    return v;
  endfunction

  // Reference: flat byte array, big-endian byte order, faults from arithmetic on the offset.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] din,
                       output logic [31:0] ed, output logic [1:0] ec);
    logic [31:0] off;
    longint      nb;
    longint      v;
    off = addr - BASE;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3) ec = 2'd1;
    else if (longint'({32'b0, off}) + nb > DEPTH) ec = 2'd2;
    else if ((longint'({32'b0, off}) % nb) != 0) ec = 2'd3;
    else ec = 2'd0;
    ed = 32'h0;
    if (ec == 2'd0) begin
      if (wr) begin
        for (int i = 0; i < nb; i++)
          ref_mem[int'(off) + i] = 8'((din >> (8 * (nb - 1 - i))) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = (v << 8) | longint'(ref_mem[int'(off) + i]);
        if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
        ed = v[31:0];
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] din,
                       output logic [31:0] gd, output logic gf, output logic [1:0] gc);
    int waitc;
    waitc = 0;
    @(negedge clock);
    w_req_valid  = 1'b1;
    w_write_op   = wr;
    w_size       = sz;
    w_unsigned   = uns;
    w_addr_32    = addr;
    w_data_in_32 = din;
    while (!w_req_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    if (!w_req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    @(posedge clock);
    #1;
    chk("rsp_valid", {31'b0, w_rsp_valid}, 32'h1);
    gd = w_data_out_32;
    gf = w_fault;
    gc = w_fault_code;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    w_req_valid = 1'b0;
    w_write_op  = 1'b0;
    @(posedge clock);
    #1;
    chk("rsp_idle", {31'b0, w_rsp_valid}, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, w_req_ready}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'b0, w_rsp_valid}, 32'h0);
    chk({tag, "_data"}, w_data_out_32, 32'h0);
    chk({tag, "_fault"}, {31'b0, w_fault}, 32'h0);
    chk({tag, "_code"}, {30'b0, w_fault_code}, 32'h0);
  endtask

  // Release reset with a load held on the request lines; returns how many edges ready stayed low.
  task automatic count_clear(output int n, output int spur);
    @(negedge clock);
    reset        = 1'b0;
    w_req_valid  = 1'b1;
    w_write_op   = 1'b0;
    w_size       = 2'b10;
    w_addr_32    = BASE;
    n = 0;
    spur = 0;
    while (!w_req_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (w_rsp_valid) spur++;
    end
    @(negedge clock);
    w_req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] gd, ed;
    logic        gf;
    logic [1:0]  gc, ec;
    int          n, spur;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    vecs.push_back(mk(0, 2, 0, 32'h80020000, 32'h0,        32'h00000000, 2'd0));
    vecs.push_back(mk(1, 2, 0, 32'h80020004, 32'hDEADBEEF, 32'h00000000, 2'd0));
    vecs.push_back(mk(0, 0, 0, 32'h80020004, 32'h0,        32'hFFFFFFDE, 2'd0));
    vecs.push_back(mk(0, 0, 1, 32'h80020007, 32'h0,        32'h000000EF, 2'd0));
    vecs.push_back(mk(1, 1, 0, 32'h80020002, 32'h00008001, 32'h00000000, 2'd0));
    vecs.push_back(mk(0, 1, 0, 32'h80020002, 32'h0,        32'hFFFF8001, 2'd0));
    vecs.push_back(mk(0, 1, 1, 32'h80020002, 32'h0,        32'h00008001, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h80020000, 32'h0,        32'h00008001, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h80020002, 32'h0,        32'h00000000, 2'd3));
    vecs.push_back(mk(1, 2, 0, 32'h8001FFFC, 32'h12345678, 32'h00000000, 2'd2));
    vecs.push_back(mk(0, 2, 0, 32'h80020000, 32'h0,        32'h00008001, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h80020004, 32'h0,        32'hDEADBEEF, 2'd0));
    vecs.push_back(mk(0, 3, 0, 32'h8001FFFF, 32'h0,        32'h00000000, 2'd1));
    vecs.push_back(mk(1, 3, 0, 32'h80020000, 32'hFFFFFFFF, 32'h00000000, 2'd1));
    vecs.push_back(mk(0, 2, 0, 32'h80020000, 32'h0,        32'h00008001, 2'd0));
    vecs.push_back(mk(0, 0, 0, 32'h8002003F, 32'h0,        32'h00000000, 2'd0));
    vecs.push_back(mk(0, 1, 0, 32'h8002003F, 32'h0,        32'h00000000, 2'd2));
    vecs.push_back(mk(1, 2, 0, 32'h8002003C, 32'hA5A50F0F, 32'h00000000, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h8002003C, 32'h0,        32'hA5A50F0F, 2'd0));
    vecs.push_back(mk(0, 1, 0, 32'h8002003C, 32'h0,        32'hFFFFA5A5, 2'd0));
    vecs.push_back(mk(0, 1, 1, 32'h8002003E, 32'h0,        32'h00000F0F, 2'd0));
    vecs.push_back(mk(0, 0, 0, 32'h8002003F, 32'h0,        32'h0000000F, 2'd0));
    vecs.push_back(mk(0, 0, 0, 32'h8002003D, 32'h0,        32'hFFFFFFA5, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h80020040, 32'h0,        32'h00000000, 2'd2));
    vecs.push_back(mk(0, 0, 1, 32'h80020040, 32'h0,        32'h00000000, 2'd2));
    vecs.push_back(mk(1, 0, 0, 32'h80020005, 32'h000000AA, 32'h00000000, 2'd0));
    vecs.push_back(mk(0, 2, 0, 32'h80020004, 32'h0,        32'hDEAABEEF, 2'd0));
    vecs.push_back(mk(0, 1, 0, 32'h80020001, 32'h0,        32'h00000000, 2'd3));

    // Reset state, then the clear sweep.
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    count_clear(n, spur);
    chk("clear_cycles", n, 32'd16);
    chk("clear_spurious_rsp", spur, 32'd0);

    // Directed table, issued back to back.
    foreach (vecs[i]) begin
      issue(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].din, gd, gf, gc);
      model(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].din, ed, ec);
      chk($sformatf("vec%0d_data", i), gd, vecs[i].exp_d);
      chk($sformatf("vec%0d_fault", i), {31'b0, gf}, {31'b0, vecs[i].exp_c != 2'd0});
      chk($sformatf("vec%0d_code", i), {30'b0, gc}, {30'b0, vecs[i].exp_c});
    end
    idle_cycle();

    // Randomized traffic against the byte-array reference.
    for (int i = 0; i < 400; i++) begin
      logic        wr, uns;
      logic [1:0]  sz;
      logic [31:0] addr, din;
      int          sel;
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      din = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = BASE + 32'($urandom_range(0, DEPTH - 1));
      else if (sel < 8)  addr = BASE + 32'($urandom_range(DEPTH - 4, DEPTH + 4));
      else if (sel == 8) addr = BASE - 32'($urandom_range(1, 4));
      else               addr = $urandom;
      if ($urandom_range(0, 3) == 0) idle_cycle();
      issue(wr, sz, uns, addr, din, gd, gf, gc);
      model(wr, sz, uns, addr, din, ed, ec);
      chk("rand_data", gd, ed);
      chk("rand_fault", {31'b0, gf}, {31'b0, ec != 2'd0});
      chk("rand_code", {30'b0, gc}, {30'b0, ec});
    end

    // Reset mid-stream: the pending response is dropped and nothing new is accepted.
    issue(1'b1, 2'd2, 1'b0, BASE + 32'd8, 32'h55AA55AA, gd, gf, gc);
    @(negedge clock);
    reset        = 1'b1;
    w_req_valid  = 1'b1;
    w_write_op   = 1'b0;
    w_size       = 2'd2;
    w_addr_32    = BASE + 32'd8;
    @(posedge clock);
    #1;
    check_zero_outputs("midstream_reset");

    // Start a clear, interrupt it, and require a full restart of the sweep.
    @(negedge clock);
    reset       = 1'b0;
    w_req_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("midclear_ready", {31'b0, w_req_ready}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero_outputs("midclear_reset");
    count_clear(n, spur);
    chk("reclear_cycles", n, 32'd16);
    chk("reclear_spurious_rsp", spur, 32'd0);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    for (int w = 0; w < DEPTH / 4; w++) begin
      issue(1'b0, 2'd2, 1'b0, BASE + 32'(4 * w), 32'h0, gd, gf, gc);
      model(1'b0, 2'd2, 1'b0, BASE + 32'(4 * w), 32'h0, ed, ec);
      chk($sformatf("cleared_word%0d", w), gd, ed);
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
